wb_mem8_slave: RTL and testbench



---
 rtl/wb_mem8_pkg.sv | 25 ++
 rtl/wb_mem8_slave.sv | 165 ++++++++++++++++
 tb/tb_wb_mem8_slave.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem8_pkg.sv
// Shared definitions for the Wishbone-to-8-bit external memory bridge:
// FSM encoding, byte-lane to device-offset mapping and beat timing.
package wb_mem8_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_ACK    = 3'd4
   } state_t;

   localparam int WAIT_CNT_W = 4;

   // Big-endian lanes: sel[3] carries byte offset 0, sel[0] carries offset 3.
   function automatic logic [1:0] lane_to_offset(input logic [1:0] lane);
      return 2'd3 - lane;
   endfunction

   // Clock cycles per byte beat: SETUP + (wait_cycles+1) STROBE + HOLD.
   function automatic int beat_len(input int wait_cycles);
      return wait_cycles + 3;
   endfunction

endpackage

// File: rtl/wb_mem8_slave.sv
// Wishbone classic 32-bit slave fronting an 8-bit asynchronous SRAM/flash.
// Each selected byte lane becomes one SETUP/STROBE/HOLD beat on the device bus.
module wb_mem8_slave
   import wb_mem8_pkg::*;
#(
   parameter int ADDR_W      = 21,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   output logic              wb_ack_o,
   output logic [ADDR_W-1:0] mem_adr_o,
   output logic [7:0]        mem_dat_o,
   input  logic [7:0]        mem_dat_i,
   output logic              mem_dat_oe_o,
   output logic              mem_cs_n_o,
   output logic              mem_oe_n_o,
   output logic              mem_we_n_o
);

   state_t                  state_reg, state_next;
   logic [ADDR_W-1:2]       adr_reg;
   logic [31:0]             dat_reg;
   logic [3:0]              pending_reg;
   logic                    we_reg;
   logic                    abort_reg;
   logic [1:0]              lane_reg, lane_next;
   logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
   logic [31:0]             rd_dat_reg;
   logic                    ack_reg;
   logic [ADDR_W-1:0]       mem_adr_reg;
   logic [7:0]              mem_dat_reg;
   logic                    dat_oe_reg, cs_n_reg, oe_n_reg, we_n_reg;

   logic                    req;
   logic [3:0]              lane_mask;
   logic [3:0]              enc_in;
   logic [ADDR_W-1:2]       base_adr;
   logic [31:0]             src_dat;
   logic                    src_we;
   logic                    strobe_done;
   logic                    abort_now;
   logic                    beat_next;
   logic                    unused_adr_bits;

   assign req         = wb_cyc_i & wb_stb_i;
   assign lane_mask   = 4'b0001 << lane_reg;
   assign strobe_done = (wait_cnt_reg == '0);
   assign abort_now   = abort_reg | ~wb_cyc_i;

   // While idle the request is not latched yet, so the first beat takes its
   // address, data and direction straight from the bus.
   assign base_adr = (state_reg == ST_IDLE) ? wb_adr_i[ADDR_W-1:2] : adr_reg;
   assign src_dat  = (state_reg == ST_IDLE) ? wb_dat_i : dat_reg;
   assign src_we   = (state_reg == ST_IDLE) ? wb_we_i  : we_reg;
   assign enc_in   = (state_reg == ST_IDLE) ? wb_sel_i : (pending_reg & ~lane_mask);

   assign unused_adr_bits = ^{wb_adr_i[31:ADDR_W], wb_adr_i[1:0]};

   always_comb begin
      lane_next = lane_reg;
      if (enc_in[3])      lane_next = 2'd3;
      else if (enc_in[2]) lane_next = 2'd2;
      else if (enc_in[1]) lane_next = 2'd1;
      else if (enc_in[0]) lane_next = 2'd0;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (req) state_next = (wb_sel_i == 4'b0000) ? ST_ACK : ST_SETUP;
         ST_SETUP:  state_next = ST_STROBE;
         ST_STROBE: if (strobe_done) state_next = ST_HOLD;
         ST_HOLD: begin
            if (abort_now)            state_next = ST_IDLE;
            else if (enc_in != 4'b0)  state_next = ST_SETUP;
            else                      state_next = ST_ACK;
         end
         ST_ACK:    state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign beat_next = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                      (state_next == ST_HOLD);

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_reg    <= ST_IDLE;
         adr_reg      <= '0;
         dat_reg      <= '0;
         pending_reg  <= '0;
         we_reg       <= 1'b0;
         abort_reg    <= 1'b0;
         lane_reg     <= '0;
         wait_cnt_reg <= '0;
         rd_dat_reg   <= '0;
         ack_reg      <= 1'b0;
         mem_adr_reg  <= '0;
         mem_dat_reg  <= '0;
         dat_oe_reg   <= 1'b0;
         cs_n_reg     <= 1'b1;
         oe_n_reg     <= 1'b1;
         we_n_reg     <= 1'b1;
      end else begin
         state_reg <= state_next;

         case (state_reg)
            ST_IDLE: begin
               if (req) begin
                  adr_reg     <= wb_adr_i[ADDR_W-1:2];
                  dat_reg     <= wb_dat_i;
                  pending_reg <= wb_sel_i;
                  we_reg      <= wb_we_i;
                  abort_reg   <= 1'b0;
                  rd_dat_reg  <= '0;
               end
            end
            ST_SETUP: begin
               wait_cnt_reg <= WAIT_CNT_W'(WAIT_CYCLES);
               if (!wb_cyc_i) abort_reg <= 1'b1;
            end
            ST_STROBE: begin
               if (!wb_cyc_i) abort_reg <= 1'b1;
               if (!strobe_done)
                  wait_cnt_reg <= wait_cnt_reg - 1'b1;
               else if (!we_reg)
                  rd_dat_reg[{lane_reg, 3'b000} +: 8] <= mem_dat_i;
            end
            ST_HOLD:   pending_reg <= pending_reg & ~lane_mask;
            default:   ;
         endcase

         if (state_next == ST_SETUP) begin
            lane_reg    <= lane_next;
            mem_adr_reg <= {base_adr, lane_to_offset(lane_next)};
            if (src_we) mem_dat_reg <= src_dat[{lane_next, 3'b000} +: 8];
         end

         // Device strobes are registered from the next state so they never glitch.
         ack_reg    <= (state_next == ST_ACK);
         cs_n_reg   <= ~beat_next;
         dat_oe_reg <= beat_next & src_we;
         oe_n_reg   <= ~((state_next == ST_STROBE) & ~src_we);
         we_n_reg   <= ~((state_next == ST_STROBE) &  src_we);
      end
   end

   assign wb_dat_o     = rd_dat_reg;
   assign wb_ack_o     = ack_reg;
   assign mem_adr_o    = mem_adr_reg;
   assign mem_dat_o    = mem_dat_reg;
   assign mem_dat_oe_o = dat_oe_reg;
   assign mem_cs_n_o   = cs_n_reg;
   assign mem_oe_n_o   = oe_n_reg;
   assign mem_we_n_o   = we_n_reg;

endmodule

// File: tb/tb_wb_mem8_slave.sv
// Bench for wb_mem8_slave: device model, beat scoreboard and per-scenario tasks.
module tb_wb_mem8_slave;

   localparam int WAITC = 1;
   localparam int B     = WAITC + 3;

   logic        clk;
   logic        rst_n;
   logic [31:0] adr, wdat, rdat_o;
   logic [3:0]  sel;
   logic        we, stb, cyc, ack;
   logic [20:0] mem_adr;
   logic [7:0]  mem_dout, mem_din;
   logic        mem_oe, cs_n, oe_n, we_n;

   int errors = 0;
   int checks = 0;
   int viol = 0;
   int cs_low_cycles = 0;

   typedef struct {
      bit          we;
      logic [20:0] adr;
      logic [7:0]  dat;
      int          len;
   } beat_t;

   beat_t exp_q[$];
   logic [7:0] dev_mem [0:255];

   wb_mem8_slave #(.ADDR_W(21), .WAIT_CYCLES(WAITC)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_o), .wb_sel_i(sel),
      .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
      .mem_adr_o(mem_adr), .mem_dat_o(mem_dout), .mem_dat_i(mem_din),
      .mem_dat_oe_o(mem_oe), .mem_cs_n_o(cs_n), .mem_oe_n_o(oe_n), .mem_we_n_o(we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous device: drives a junk byte whenever it is not being read.
   assign mem_din = (!cs_n && !oe_n) ? dev_mem[mem_adr[7:0]] : 8'h5A;

   // Beat monitor: captures each strobe pulse and compares it against the scoreboard.
   bit          in_beat = 0;
   bit          cur_we;
   logic [20:0] cur_adr;
   logic [7:0]  cur_dat;
   int          cur_len;
   bit          cur_ok;
   beat_t       e;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_beat = 0;
      end else begin
         if (!oe_n && !we_n) viol++;
         if (!oe_n && mem_oe) viol++;
         if (!cs_n) cs_low_cycles++;
         if ((!oe_n || !we_n) && !in_beat) begin
            in_beat = 1;
            cur_we  = !we_n;
            cur_adr = mem_adr;
            cur_dat = !we_n ? mem_dout : 8'h00;
            cur_len = 1;
            cur_ok  = (cs_n == 1'b0) && (mem_oe == !we_n);
         end else if ((!oe_n || !we_n) && in_beat) begin
            cur_len++;
            if (mem_adr !== cur_adr || cs_n !== 1'b0 || mem_oe !== cur_we) cur_ok = 0;
         end else if (in_beat) begin
            in_beat = 0;
            if (cs_n !== 1'b0 || mem_adr !== cur_adr || mem_oe !== cur_we) cur_ok = 0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected got we=%0d adr=%h dat=%h required no beat",
                        cur_we, cur_adr, cur_dat);
            end else begin
               e = exp_q.pop_front();
               if (cur_we !== e.we || cur_adr !== e.adr || cur_dat !== e.dat ||
                   cur_len !== e.len || !cur_ok) begin
                  errors++;
                  $display("FAIL beat got we=%0d adr=%h dat=%h len=%0d hold_ok=%0d required we=%0d adr=%h dat=%h len=%0d hold_ok=1",
                           cur_we, cur_adr, cur_dat, cur_len, cur_ok, e.we, e.adr, e.dat, e.len);
               end else begin
                  $display("beat we=%0d adr=%h dat=%h len=%0d", cur_we, cur_adr, cur_dat, cur_len);
               end
            end
         end
      end
   end

   task automatic push_beat(input bit w, input logic [20:0] a, input logic [7:0] d);
      beat_t b;
      b.we = w; b.adr = a; b.dat = d; b.len = WAITC + 1;
      exp_q.push_back(b);
   endtask

   task automatic run_xfer(input logic [31:0] a, input logic [3:0] s, input logic w,
                           input logic [31:0] d, output int edges,
                           output logic [31:0] rd, output logic ack_after);
      @(negedge clk);
      adr = a; sel = s; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
      edges = -1;
      rd = 'x;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            edges = i;
            rd = rdat_o;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      ack_after = ack;
      $display("xfer adr=%h sel=%b we=%0d wdat=%h rdata=%h edges=%0d", a, s, w, d, rd, edges);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL reset_ack got %b required 0", ack); end
      checks++; if (rdat_o !== 32'h0) begin errors++; $display("FAIL reset_dat_o got %h required 0", rdat_o); end
      checks++; if (mem_adr !== 21'h0) begin errors++; $display("FAIL reset_mem_adr got %h required 0", mem_adr); end
      checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dat got %h required 0", mem_dout); end
      checks++; if (mem_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe got %b required 0", mem_oe); end
      checks++; if ({cs_n, oe_n, we_n} !== 3'b111) begin errors++; $display("FAIL reset_strobes got %b required 111", {cs_n, oe_n, we_n}); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({ack, cs_n} !== 2'b01) begin errors++; $display("FAIL post_reset_idle got ack/cs_n=%b required 01", {ack, cs_n}); end
   endtask

   task automatic test_read_word;
      int edges; logic [31:0] rd; logic aa;
      for (int i = 0; i < 4; i++) push_beat(0, 21'h10 + 21'(i), 8'h00);
      run_xfer(32'h10, 4'b1111, 0, 32'h0, edges, rd, aa);
      checks++; if (edges !== 4 * B) begin errors++; $display("FAIL read_word_latency got %0d required %0d", edges, 4 * B); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_word_data got %h required deadbeef", rd); end
      checks++; if (aa !== 1'b0) begin errors++; $display("FAIL ack_single_cycle got %b required 0", aa); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL read_word_beats pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_sel_zero;
      int edges; logic [31:0] rd; logic aa; int cs0;
      cs0 = cs_low_cycles;
      run_xfer(32'h10, 4'b0000, 0, 32'h0, edges, rd, aa);
      checks++; if (edges !== 0) begin errors++; $display("FAIL sel0_latency got %0d required 0", edges); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sel0_data got %h required 0", rd); end
      checks++; if (cs_low_cycles !== cs0) begin errors++; $display("FAIL sel0_cs got %0d low cycles required 0", cs_low_cycles - cs0); end
   endtask

   task automatic test_write_lane;
      int edges; logic [31:0] rd; logic aa;
      push_beat(1, 21'h21, 8'h22);
      run_xfer(32'h20, 4'b0100, 1, 32'h11223344, edges, rd, aa);
      checks++; if (edges !== B) begin errors++; $display("FAIL write_lane_latency got %0d required %0d", edges, B); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL write_lane_beats pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_sparse_read;
      int edges; logic [31:0] rd; logic aa;
      push_beat(0, 21'h30, 8'h00);
      push_beat(0, 21'h33, 8'h00);
      run_xfer(32'h30, 4'b1001, 0, 32'h0, edges, rd, aa);
      checks++; if (edges !== 2 * B) begin errors++; $display("FAIL sparse_latency got %0d required %0d", edges, 2 * B); end
      checks++; if (rd !== 32'hAA0000DD) begin errors++; $display("FAIL sparse_data got %h required aa0000dd", rd); end
   endtask

   task automatic test_cyc_drop;
      bit found; bit ack_seen;
      push_beat(1, 21'h40, 8'h01);
      push_beat(1, 21'h41, 8'h02);
      @(negedge clk);
      adr = 32'h40; sel = 4'b1111; we = 1; wdat = 32'h01020304; cyc = 1; stb = 1;
      found = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!we_n && mem_adr == 21'h41) begin found = 1; break; end
      end
      cyc = 0; stb = 0;
      ack_seen = 0;
      for (int i = 0; i < 5 * B; i++) begin
         @(posedge clk); #1;
         if (ack) ack_seen = 1;
      end
      $display("xfer cyc_drop adr=40 sel=1111 reached_lane2=%0d ack_seen=%0d", found, ack_seen);
      checks++; if (!found) begin errors++; $display("FAIL cyc_drop_lane2 got no strobe required strobe at 000041"); end
      checks++; if (ack_seen) begin errors++; $display("FAIL cyc_drop_ack got 1 required 0"); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cyc_drop_beats pending got %0d required 0", exp_q.size()); end
      checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL cyc_drop_cs got %b required 1", cs_n); end
   endtask

   task automatic test_reset_mid;
      bit found;
      @(negedge clk);
      adr = 32'h50; sel = 4'b1000; we = 1; wdat = 32'h99887766; cyc = 1; stb = 1;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!we_n) begin found = 1; break; end
      end
      #2 rst_n = 1'b0;
      #1;
      $display("xfer reset_mid adr=50 strobe_reached=%0d strobes=%b dat_oe=%b", found, {cs_n, we_n}, mem_oe);
      checks++; if (!found) begin errors++; $display("FAIL reset_mid_strobe got none required we_n low"); end
      checks++; if ({cs_n, we_n} !== 2'b11) begin errors++; $display("FAIL reset_mid_strobes got %b required 11", {cs_n, we_n}); end
      checks++; if (mem_oe !== 1'b0) begin errors++; $display("FAIL reset_mid_dat_oe got %b required 0", mem_oe); end
      cyc = 0; stb = 0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int edges; logic [31:0] rd1, rd2;
      push_beat(0, 21'h33, 8'h00);
      push_beat(0, 21'h10, 8'h00);
      @(negedge clk);
      adr = 32'h30; sel = 4'b0001; we = 0; cyc = 1; stb = 1;
      edges = -1; rd1 = 'x; rd2 = 'x;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (ack) begin edges = i; rd1 = rdat_o; break; end
      end
      checks++; if (edges !== B) begin errors++; $display("FAIL b2b_first_latency got %0d required %0d", edges, B); end
      checks++; if (rd1 !== 32'h000000DD) begin errors++; $display("FAIL b2b_first_data got %h required 000000dd", rd1); end
      adr = 32'h10; sel = 4'b1000;
      edges = -1;
      for (int i = 1; i < 100; i++) begin
         @(posedge clk); #1;
         if (ack) begin edges = i; rd2 = rdat_o; break; end
      end
      cyc = 0; stb = 0;
      @(posedge clk); #1;
      $display("xfer back_to_back rdata1=%h rdata2=%h gap_edges=%0d", rd1, rd2, edges);
      checks++; if (edges !== 2 + B) begin errors++; $display("FAIL b2b_second_latency got %0d required %0d", edges, 2 + B); end
      checks++; if (rd2 !== 32'hDE000000) begin errors++; $display("FAIL b2b_second_data got %h required de000000", rd2); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_beats pending got %0d required 0", exp_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) dev_mem[i] = 8'h00;
      dev_mem[8'h10] = 8'hDE; dev_mem[8'h11] = 8'hAD;
      dev_mem[8'h12] = 8'hBE; dev_mem[8'h13] = 8'hEF;
      dev_mem[8'h30] = 8'hAA; dev_mem[8'h31] = 8'hBB;
      dev_mem[8'h32] = 8'hCC; dev_mem[8'h33] = 8'hDD;

      test_reset();
      test_read_word();
      test_sel_zero();
      test_write_lane();
      test_sparse_read();
      test_cyc_drop();
      test_reset_mid();
      test_back_to_back();

      checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_exclusion got %0d violations required 0", viol); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
